// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the IF/ID buffer: immediate-type codes, RV32I opcodes and the NOP word.
// The immediate generator in decode uses the same IMM_* codes.
package if_id_buffer_pkg;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-side and decode-side handshake bundle for the IF/ID buffer.
// The buffer uses the slave modport; the fetch/decode environment uses master.
interface if_id_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  out_imm_sel;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_imm_sel
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_imm_sel
  );
endinterface

// File: rtl/if_id_buffer_imm_decode.sv
// Combinational RV32I opcode to immediate-type classifier (module ifid_imm_decode).
module ifid_imm_decode
  import if_id_buffer_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [2:0] o_imm_sel
);

  // opcode to immediate-format lookup
  always_comb begin
    o_imm_sel = IMM_NONE;
    case (i_opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: o_imm_sel = IMM_I;
      OP_STORE:                            o_imm_sel = IMM_S;
      OP_BRANCH:                           o_imm_sel = IMM_B;
      OP_LUI, OP_AUIPC:                    o_imm_sel = IMM_U;
      OP_JAL:                              o_imm_sel = IMM_J;
      default:                             o_imm_sel = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry in-order skid FIFO between fetch and decode carrying {pc, instr, imm_sel}.
// Optional feature macro: IFID_IMM_SEL_DECODE_EN (decode and store imm_sel at push).
module if_id_buffer
  import if_id_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  if_id_buffer_if.slave bus
);

  logic [1:0]  r_count;
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [31:0] r_pc    [2];
  logic [31:0] r_instr [2];

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_instr;

  assign w_full  = (r_count == 2'd2);
  assign w_empty = (r_count == 2'd0);

  // Handshakes come only from registered occupancy; rst forces both low in its own cycle.
  assign bus.in_ready  = ~rst & ~w_full;
  assign bus.out_valid = ~rst & ~w_empty;

  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  // occupancy, pointers and entry payload
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_pc[i]    <= 32'd0;
        r_instr[i] <= 32'd0;
      end
    end else if (bus.flush) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_pc[r_wr_ptr]    <= bus.in_pc;
        r_instr[r_wr_ptr] <= bus.in_instr;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // head entry, or a NOP at pc 0 when empty
  always_comb begin
    w_out_pc    = 32'd0;
    w_out_instr = NOP_INSTR;
    if (!w_empty) begin
      w_out_pc    = r_pc[r_rd_ptr];
      w_out_instr = r_instr[r_rd_ptr];
    end else begin
      w_out_pc    = 32'd0;
      w_out_instr = NOP_INSTR;
    end
  end

  assign bus.out_pc    = w_out_pc;
  assign bus.out_instr = w_out_instr;

`ifdef IFID_IMM_SEL_DECODE_EN
  logic [2:0] r_imm [2];
  logic [2:0] w_in_imm;

  ifid_imm_decode u_imm_decode (
    .i_opcode  (bus.in_instr[6:0]),
    .o_imm_sel (w_in_imm)
  );

  // imm_sel storage alongside each entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_imm[0] <= IMM_I;
      r_imm[1] <= IMM_I;
    end else if (bus.flush) begin
      r_imm[0] <= r_imm[0];
      r_imm[1] <= r_imm[1];
    end else if (w_push) begin
      r_imm[r_wr_ptr] <= w_in_imm;
    end else begin
      r_imm[0] <= r_imm[0];
      r_imm[1] <= r_imm[1];
    end
  end

  assign bus.out_imm_sel = w_empty ? IMM_I : r_imm[r_rd_ptr];
`else
  assign bus.out_imm_sel = IMM_NONE;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: queue-based reference model compared every cycle,
// plus hand-computed literal checks on reset, ordering, streaming, flush and reset-at-full.
module tb_if_id_buffer;

  logic clk;
  logic rst;
  if_id_buffer_if bus ();

  if_id_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t model_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  bit     chk_en   = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Immediate format from the opcode table of the ISA.
  function automatic logic [2:0] ref_imm(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) return 3'b000;
    if (op == 7'h23) return 3'b001;
    if (op == 7'h63) return 3'b010;
    if (op == 7'h37 || op == 7'h17) return 3'b011;
    if (op == 7'h6F) return 3'b100;
    return 3'b111;
  endfunction

  function automatic logic [2:0] built_imm(input logic [2:0] v);
`ifdef IFID_IMM_SEL_DECODE_EN
    return v;
`else
    return 3'b111;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO of depth 2, flush and rst empty it, handshake accepted only when ready.
  always @(posedge clk) begin
    bit do_pop, do_push;
    entry_t e;
    if (rst || bus.flush) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() != 0) && bus.out_ready;
      do_push = bus.in_valid && (model_q.size() < 2);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.pc = bus.in_pc;
        e.instr = bus.in_instr;
        model_q.push_back(e);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!rst && model_q.size() < 2)});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, (!rst && model_q.size() != 0)});
      if (!rst) begin
        if (model_q.size() != 0) begin
          chk("out_pc", bus.out_pc, model_q[0].pc);
          chk("out_instr", bus.out_instr, model_q[0].instr);
          chk("out_imm_sel", {29'd0, bus.out_imm_sel}, {29'd0, built_imm(ref_imm(model_q[0].instr))});
        end else begin
          chk("out_pc_empty", bus.out_pc, 32'd0);
          chk("out_instr_empty", bus.out_instr, NOP);
          chk("out_imm_sel_empty", {29'd0, bus.out_imm_sel}, {29'd0, built_imm(3'b000)});
        end
      end
    end
  end

  task automatic drive(input logic r, input logic iv, input logic [31:0] pc,
                       input logic [31:0] instr, input logic ordy, input logic fl);
    rst          = r;
    bus.in_valid = iv;
    bus.in_pc    = pc;
    bus.in_instr = instr;
    bus.out_ready = ordy;
    bus.flush    = fl;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] s_instr [8];
  logic [2:0]  s_imm   [8];

  initial begin
    s_instr = '{32'h00208463, 32'h123450B7, 32'h0080006F, 32'h002081B3,
                32'h00001097, 32'h00312223, 32'h00012083, 32'h000080E7};
    s_imm   = '{3'b010, 3'b011, 3'b100, 3'b111, 3'b011, 3'b001, 3'b000, 3'b000};

    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_cycle_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_cycle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk_en = 1'b1;

    // reset then idle
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_rst_instr", bus.out_instr, 32'h0000_0013);
    chk("post_rst_pc", bus.out_pc, 32'd0);
    tick();

    // fill to two, then drain in order
    drive(1'b0, 1'b1, 32'h100, 32'h00500093, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h104, 32'h00112023, 1'b0, 1'b0);
    chk("lat1_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lat1_pc", bus.out_pc, 32'h100);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("full_head_pc", bus.out_pc, 32'h100);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("pop0_instr", bus.out_instr, 32'h00500093);
    chk("pop0_imm", {29'd0, bus.out_imm_sel}, {29'd0, built_imm(3'b000)});
    tick();
    chk("pop1_pc", bus.out_pc, 32'h104);
    chk("pop1_instr", bus.out_instr, 32'h00112023);
    chk("pop1_imm", {29'd0, bus.out_imm_sel}, {29'd0, built_imm(3'b001)});
    chk("ready_rises_after_pop", {31'd0, bus.in_ready}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("drained_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();

    // back-to-back stream across pointer wrap
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 32'h200 + 32'(4 * i), s_instr[i], 1'b1, 1'b0);
      if (i > 0) begin
        chk("stream_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stream_pc", bus.out_pc, 32'h200 + 32'(4 * (i - 1)));
        chk("stream_imm", {29'd0, bus.out_imm_sel}, {29'd0, built_imm(s_imm[i - 1])});
      end
      tick();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("stream_last_pc", bus.out_pc, 32'h21C);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    // flush at count 2 while pushing a JAL
    drive(1'b0, 1'b1, 32'h300, 32'h00500093, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h304, 32'h00112023, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h308, 32'h0000006F, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("flush_full_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_full_instr", bus.out_instr, NOP);
    tick();
    // flush at count 1 with an accepted handshake that must be discarded
    drive(1'b0, 1'b1, 32'h400, 32'h00500093, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h404, 32'h0000006F, 1'b0, 1'b1);
    chk("flush_cycle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("flush_one_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    tick();

    // reset at count 2 with simultaneous push and pop
    drive(1'b0, 1'b1, 32'h500, 32'h00208463, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h504, 32'h123450B7, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h508, 32'h0080006F, 1'b1, 1'b0);
    chk("rst_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_full_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_full_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    tick();
    drive(1'b0, 1'b1, 32'h600, 32'h00012083, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("after_rst_pc", bus.out_pc, 32'h600);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
